gcd_lcm_coprocessor: RTL

- Responder end of the core's coprocessor handshake. The core raises Start and drives the operand/opcode word WDFinal, then stalls until the done flag (AnsData[8]) is seen.
- This block latches the operands, computes GCD (Euclid, subtractive) or LCM ((A/gcd)*B via restoring divide), and holds the result and done flag until Start drops.
- It sits beside the data memory in the top level, fed by the core's Start/WDFinal and driving the core's AnsData input.

---
 rtl/gcd_lcm_coprocessor.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/gcd_lcm_coprocessor.sv
// Coprocessor responder: latches operands from the core, computes GCD by
// subtractive Euclid or LCM as (A/gcd)*B, and holds the result until start drops.
module gcd_lcm_coprocessor #(
  parameter int W          = 8,
  parameter int DIV_CYCLES = W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] wd_final,
  output logic [31:0] ans_data
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, CALC, DIV, MUL, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [W-1:0]     a0_q, a0_d, b0_q, b0_d;
  logic             op_q, op_d;
  logic             err_q, err_d;
  logic [2*W-1:0]   result_q, result_d;
  logic [W-1:0]     rem_q, rem_d, quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [31:0]      ans_q, ans_d;

  logic [W:0]       trial;
  logic             trialGe;
  logic [W-1:0]     trialDiff;
  logic             busy, done;
  logic             unused_wd;

  assign unused_wd = ^wd_final[31:2*W+1];

  // Restoring-divide step: shift in the next dividend bit and subtract g if it fits.
  // The difference fits in W bits whenever the subtraction is taken.
  assign trial     = {rem_q, quo_q[W-1]};
  assign trialGe   = trial >= {1'b0, b_q};
  assign trialDiff = trial[W-1:0] - b_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    a0_d     = a0_q;
    b0_d     = b0_q;
    op_d     = op_q;
    err_d    = err_q;
    result_d = result_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a0_d     = wd_final[W-1:0];
          b0_d     = wd_final[2*W-1:W];
          op_d     = wd_final[2*W];
          a_d      = wd_final[W-1:0];
          b_d      = wd_final[2*W-1:W];
          result_d = '0;
          err_d    = 1'b0;
          state_d  = CALC;
        end
      end
      CALC: begin
        if (!start) begin
          result_d = '0;
          err_d    = 1'b0;
          state_d  = IDLE;
        end else if (a_q == '0 || b_q == '0) begin
          result_d = op_q ? '0 : {{W{1'b0}}, a_q | b_q};
          err_d    = (a_q == '0) && (b_q == '0);
          state_d  = DONE;
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
        end else if (b_q > a_q) begin
          b_d = b_q - a_q;
        end else if (op_q) begin
          rem_d   = '0;
          quo_d   = a0_q;
          cnt_d   = '0;
          state_d = DIV;
        end else begin
          result_d = {{W{1'b0}}, a_q};
          state_d  = DONE;
        end
      end
      DIV: begin
        if (!start) begin
          result_d = '0;
          err_d    = 1'b0;
          state_d  = IDLE;
        end else begin
          rem_d = trialGe ? trialDiff : trial[W-1:0];
          quo_d = {quo_q[W-2:0], trialGe};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(DIV_CYCLES - 1)) state_d = MUL;
        end
      end
      MUL: begin
        if (!start) begin
          result_d = '0;
          err_d    = 1'b0;
          state_d  = IDLE;
        end else begin
          result_d = (2*W)'(quo_q) * (2*W)'(b0_q);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (!start) begin
          result_d = '0;
          err_d    = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output word is registered from the current state; leaving to IDLE clears it on the same edge.
  always_comb begin
    busy  = (state_q == CALC) || (state_q == DIV) || (state_q == MUL);
    done  = (state_q == DONE);
    ans_d = '0;
    if (state_d != IDLE) begin
      ans_d = {done ? result_q : {2*W{1'b0}}, 5'b0, busy, done & err_q, done,
               done ? result_q[W-1:0] : {W{1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      a0_q     <= '0;
      b0_q     <= '0;
      op_q     <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      ans_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      a0_q     <= a0_d;
      b0_q     <= b0_d;
      op_q     <= op_d;
      err_q    <= err_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      ans_q    <= ans_d;
    end
  end

  assign ans_data = ans_q;

endmodule
